// File: rtl/tmds_decoder.sv
// TMDS receive channel: bit-slip alignment on control tokens, then per-symbol decode to pixel byte or control value.
module tmds_decoder #(
  parameter int LOCK_COUNT = 8,
  parameter int SEARCH_LEN = 1024,
  parameter int LOSS_LEN   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sym_in,
  input  logic       sym_valid,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       out_valid,
  output logic       locked,
  output logic [3:0] slip
);

  localparam int RW   = $clog2(LOCK_COUNT) + 1;
  localparam int GMAX = (LOSS_LEN > SEARCH_LEN) ? LOSS_LEN : SEARCH_LEN;
  localparam int GW   = $clog2(GMAX) + 1;

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state;
  logic [9:0]    prev;
  logic [RW-1:0] ctl_run;
  logic [GW-1:0] gap;

  logic [19:0]   cat;
  logic [9:0]    w;
  logic          is_ctl;
  logic [1:0]    ctl_val;
  logic [7:0]    q;
  logic [7:0]    d;
  logic [RW-1:0] run_nx;
  logic [GW-1:0] gap_nx;

  always_comb begin
    cat = {sym_in, prev};
    w   = 10'(cat >> slip);

    is_ctl  = 1'b1;
    ctl_val = 2'b00;
    case (w)
      10'h354: ctl_val = 2'b00;
      10'h0AB: ctl_val = 2'b01;
      10'h154: ctl_val = 2'b10;
      10'h2AB: ctl_val = 2'b11;
      default: is_ctl  = 1'b0;
    endcase

    q    = w[9] ? ~w[7:0] : w[7:0];
    d    = '0;
    d[0] = q[0];
    for (int unsigned i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end

    if (is_ctl) begin
      run_nx = (ctl_run >= RW'(LOCK_COUNT)) ? ctl_run : ctl_run + 1'b1;
      gap_nx = '0;
    end else begin
      run_nx = '0;
      gap_nx = (gap == '1) ? gap : gap + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      prev      <= '0;
      ctl_run   <= '0;
      gap       <= '0;
      data_out  <= '0;
      ctrl_out  <= '0;
      de_out    <= 1'b0;
      out_valid <= 1'b0;
      locked    <= 1'b0;
      slip      <= '0;
    end else begin
      out_valid <= sym_valid;
      if (sym_valid) begin
        prev    <= sym_in;
        ctl_run <= run_nx;
        gap     <= gap_nx;
        if (is_ctl) begin
          de_out   <= 1'b0;
          ctrl_out <= ctl_val;
        end else begin
          de_out   <= 1'b1;
          data_out <= d;
        end
        case (state)
          SEARCH: begin
            if (is_ctl && (run_nx >= RW'(LOCK_COUNT))) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else if (gap_nx >= GW'(SEARCH_LEN)) begin
              slip    <= (slip == 4'd9) ? 4'd0 : slip + 4'd1;
              gap     <= '0;
              ctl_run <= '0;
            end
          end
          LOCKED: begin
            if (gap_nx >= GW'(LOSS_LEN)) begin
              state   <= SEARCH;
              locked  <= 1'b0;
              ctl_run <= '0;
              gap     <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule
